// File: rtl/mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : mips_muldiv_unit
//  Purpose  : Multi-cycle multiply/divide unit owning the HI/LO pair.
//             MULT/MULTU use an iterative shift-add over WIDTH edges, and
//             DIV/DIVU use restoring division over WIDTH edges. Both are
//             followed by one FIX edge that applies the sign correction and
//             writes {hi, lo}. MTHI/MTLO write hi/lo directly from IDLE.
//  Build    : define MULDIV_FAST_MUL_EN to compute multiplies with one
//             combinational multiplier on the accept edge. The unit then
//             goes straight to FIX, and division is unchanged.
//  Ports    : clk, reset (sync, active-high), start, op[2:0],
//             src_a/src_b[WIDTH-1:0] -> busy, done (pulse),
//             dropped (pulse), hi/lo[WIDTH-1:0]
//  Revision : 1.0  initial release
// ============================================================================
module mips_muldiv_unit #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  output logic             busy,
  output logic             done,
  output logic             dropped,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;
  localparam logic [1:0] S_FIX  = 2'd3;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  logic [1:0]         state_q,   state_d;
  logic [CNT_W-1:0]   cnt_q,     cnt_d;
  logic [2*WIDTH-1:0] acc_q,     acc_d;
  logic [WIDTH-1:0]   a_q,       a_d;
  logic [WIDTH-1:0]   b_q,       b_d;
  logic               neg_q,     neg_d;     // product / quotient negative
  logic               rneg_q,    rneg_d;    // dividend was negative
  logic               is_div_q,  is_div_d;
  logic               divz_q,    divz_d;
  logic               done_q,    done_d;
  logic               dropped_q, dropped_d;
  logic [WIDTH-1:0]   hi_q,      hi_d;
  logic [WIDTH-1:0]   lo_q,      lo_d;

  // Operand magnitudes and signs. The signed ops are the even opcodes.
  logic             w_signed_op;
  logic             w_a_neg, w_b_neg;
  logic [WIDTH-1:0] w_a_abs, w_b_abs;

  assign w_signed_op = ~op[0];
  assign w_a_neg     = w_signed_op & src_a[WIDTH-1];
  assign w_b_neg     = w_signed_op & src_b[WIDTH-1];
  assign w_a_abs     = w_a_neg ? (~src_a + 1'b1) : src_a;
  assign w_b_abs     = w_b_neg ? (~src_b + 1'b1) : src_b;

  // Shift-add step. The low half of acc holds the remaining multiplier bits,
  // and the high half accumulates. The carry re-enters at the top on the shift.
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next;

  assign w_mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign w_mul_next = {w_mul_sum, acc_q[WIDTH-1:1]};

  // Restoring division step. The high half of acc is the partial remainder.
  // The low half shifts the dividend out and the quotient bits in. Because
  // remainder < divisor, the shifted value is < 2*divisor, so bit WIDTH of
  // the difference flags only a borrow.
  logic [WIDTH:0]     w_div_sh;
  logic [WIDTH:0]     w_div_diff;
  logic [2*WIDTH-1:0] w_div_next;

  assign w_div_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign w_div_diff = w_div_sh - {1'b0, b_q};
  assign w_div_next = w_div_diff[WIDTH]
                    ? {w_div_sh[WIDTH-1:0],   acc_q[WIDTH-2:0], 1'b0}
                    : {w_div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

  // Sign fixups that are applied on the FIX edge.
  logic [2*WIDTH-1:0] w_prod_fix;
  logic [WIDTH-1:0]   w_quo_fix, w_rem_fix, w_a_orig;

  assign w_prod_fix = neg_q  ? (~acc_q + 1'b1) : acc_q;
  assign w_quo_fix  = neg_q  ? (~acc_q[WIDTH-1:0] + 1'b1) : acc_q[WIDTH-1:0];
  assign w_rem_fix  = rneg_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1) : acc_q[2*WIDTH-1:WIDTH];
  // Restores the original dividend for the divide-by-zero result.
  assign w_a_orig   = rneg_q ? (~a_q + 1'b1) : a_q;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    a_d       = a_q;
    b_d       = b_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    is_div_d  = is_div_q;
    divz_d    = divz_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    done_d    = 1'b0;
    dropped_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (op)
            OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
              a_d      = w_a_abs;
              b_d      = w_b_abs;
              neg_d    = w_a_neg ^ w_b_neg;
              rneg_d   = w_a_neg;
              cnt_d    = '0;
              is_div_d = op[1];
              divz_d   = op[1] & (src_b == '0);
              if (op[1]) begin
                acc_d   = {{WIDTH{1'b0}}, w_a_abs};
                state_d = S_DIV;
              end else begin
`ifdef MULDIV_FAST_MUL_EN
                acc_d   = {{WIDTH{1'b0}}, w_a_abs} * {{WIDTH{1'b0}}, w_b_abs};
                state_d = S_FIX;
`else
                acc_d   = {{WIDTH{1'b0}}, w_b_abs};
                state_d = S_MUL;
`endif
              end
            end
            OP_MTHI: hi_d      = src_a;
            OP_MTLO: lo_d      = src_a;
            default: dropped_d = 1'b1;
          endcase
        end
      end

      S_MUL, S_DIV: begin
        acc_d = (state_q == S_DIV) ? w_div_next : w_mul_next;
        if (cnt_q == C_LAST) begin
          cnt_d   = '0;
          state_d = S_FIX;
        end else begin
          cnt_d   = cnt_q + 1'b1;
        end
      end

      default: begin  // S_FIX
        if (!is_div_q) begin
          {hi_d, lo_d} = w_prod_fix;
        end else if (divz_q) begin
          lo_d = '1;
          hi_d = w_a_orig;
        end else begin
          lo_d = w_quo_fix;
          hi_d = w_rem_fix;
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
    endcase

    // A start that arrives while busy is ignored but reported.
    if (start && (state_q != S_IDLE)) begin
      dropped_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      acc_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      neg_q     <= 1'b0;
      rneg_q    <= 1'b0;
      is_div_q  <= 1'b0;
      divz_q    <= 1'b0;
      done_q    <= 1'b0;
      dropped_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      neg_q     <= neg_d;
      rneg_q    <= rneg_d;
      is_div_q  <= is_div_d;
      divz_q    <= divz_d;
      done_q    <= done_d;
      dropped_q <= dropped_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  assign busy    = (state_q != S_IDLE);
  assign done    = done_q;
  assign dropped = dropped_q;
  assign hi      = hi_q;
  assign lo      = lo_q;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv_unit.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mips_muldiv_unit
//  Purpose  : Scoreboard bench for mips_muldiv_unit (WIDTH=32). The driver
//             pushes the expected results from an arithmetic reference model.
//             A monitor process checks done/hi/lo/busy/dropped on every
//             falling edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mips_muldiv_unit;

  localparam int W = 32;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 1;
`else
  localparam int MUL_LAT = W + 1;
`endif
  localparam int DIV_LAT = W + 1;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          start = 1'b0;
  logic [2:0]    op = 3'd0;
  logic [W-1:0]  src_a = '0;
  logic [W-1:0]  src_b = '0;
  logic          busy, done, dropped;
  logic [W-1:0]  hi, lo;

  mips_muldiv_unit #(.WIDTH(W)) dut (
    .clk    (clk),
    .reset  (reset),
    .start  (start),
    .op     (op),
    .src_a  (src_a),
    .src_b  (src_b),
    .busy   (busy),
    .done   (done),
    .dropped(dropped),
    .hi     (hi),
    .lo     (lo)
  );

  always #5 clk = ~clk;

  // The edge counter. After posedge k, cyc == k.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    int           acc;   // accept edge
    int           lat;   // edges from accept to the FIX edge
  } exp_t;

  exp_t         sb[$];
  bit           drop_set[int];
  int           free_edge = 0;
  logic [W-1:0] m_hi = '0;
  logic [W-1:0] m_lo = '0;
  bit           mon_en = 1'b0;
  int           n_pass = 0;
  int           n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
  endtask

  // Reference model that uses plain 64-bit arithmetic. It returns {hi, lo}.
  function automatic logic [63:0] ref_model(input logic [2:0] o, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
    longint sa, sbv, q, r;
    logic [63:0] ua, ub;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    ua  = {32'd0, a};
    ub  = {32'd0, b};
    case (o)
      3'd0: return sa * sbv;
      3'd1: return ua * ub;
      3'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
        q = sa / sbv;
        r = sa % sbv;
        return {r[31:0], q[31:0]};
      end
      3'd3: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {(ua % ub), 32'd0} | (ua / ub);
      end
      default: return 64'd0;
    endcase
  endfunction

  // This task is called on a falling edge. It drives one start for one cycle
  // and records what the DUT must do on that edge.
  task automatic issue(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
    int          e;
    bit          mt_acc;
    logic [63:0] r;
    exp_t        x;
    mt_acc = 1'b0;
    start = 1'b1; op = o; src_a = a; src_b = b;
    e = cyc + 1;
    if (e < free_edge || o > 3'd5) begin
      drop_set[e] = 1'b1;
    end else if (o == 3'd4 || o == 3'd5) begin
      mt_acc = 1'b1;
    end else begin
      r     = ref_model(o, a, b);
      x.hi  = r[63:32];
      x.lo  = r[31:0];
      x.acc = e;
      x.lat = (o < 3'd2) ? MUL_LAT : DIV_LAT;
      sb.push_back(x);
      free_edge = e + x.lat + 1;
    end
    @(posedge clk);
    if (mt_acc) begin
      if (o == 3'd4) m_hi = a;
      else           m_lo = a;
    end
    @(negedge clk);
    start = 1'b0;
    op    = 3'($urandom_range(0, 7));
    src_a = $urandom;
    src_b = $urandom;
  endtask

  task automatic wait_idle();
    while (cyc + 1 < free_edge) @(negedge clk);
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    start = 1'b0;
    @(posedge clk);
    sb.delete();
    drop_set.delete();
    free_edge = 0;
    m_hi = '0;
    m_lo = '0;
    mon_en = 1'b1;
    @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_dropped", dropped, 0);
    reset = 1'b0;
  endtask

  function automatic logic [W-1:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // The monitor checks results on done and the hold/busy/dropped behaviour every cycle.
  always @(negedge clk) begin
    if (mon_en && !reset) begin
      bit   busy_exp;
      exp_t x;
      busy_exp = (sb.size() > 0) && (cyc >= sb[0].acc) && (cyc < sb[0].acc + sb[0].lat);
      if (done) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          x = sb.pop_front();
          chk("latency", 64'(cyc - x.acc), 64'(x.lat));
          chk("result_hi", hi, x.hi);
          chk("result_lo", lo, x.lo);
          m_hi = x.hi;
          m_lo = x.lo;
        end
      end else begin
        chk("hold_hi", hi, m_hi);
        chk("hold_lo", lo, m_lo);
      end
      chk("busy", busy, busy_exp);
      if (dropped || drop_set.exists(cyc)) chk("dropped", dropped, drop_set.exists(cyc));
    end
  end

  initial begin
    logic [W-1:0] a, b;
    repeat (2) @(negedge clk);
    apply_reset();

    // Directed cases
    issue(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF); wait_idle();
    issue(3'd0, 32'hFFFF_FFFD, 32'd7);         wait_idle();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);         wait_idle();
    issue(3'd3, 32'd7, 32'd2);                 wait_idle();
    issue(3'd3, 32'h1234, 32'd0);              wait_idle();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF); wait_idle();
    issue(3'd2, 32'hFFFF_FF00, 32'd0);         wait_idle();

    // An MTHI issued while busy is dropped, so hi keeps the product.
    issue(3'd0, 32'h0001_2345, 32'hFFFF_FFF0);
    repeat (3) @(negedge clk);
    issue(3'd4, 32'h0000_AAAA, 32'd0);
    wait_idle();
    repeat (2) @(negedge clk);

    // MTLO in IDLE
    issue(3'd5, 32'h55, 32'd0);
    chk("mtlo_lo", lo, 32'h55);
    chk("mtlo_busy", busy, 0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    chk("mthi_hi", hi, 32'hDEAD_BEEF);

    // Reserved opcodes
    issue(3'd6, 32'd1, 32'd1);
    issue(3'd7, 32'd1, 32'd1);
    @(negedge clk);

    // Reset in the middle of an operation
    issue(3'd3, 32'hCAFE_0000, 32'd3);
    repeat (8) @(negedge clk);
    apply_reset();
    chk("midreset_hi", hi, 0);
    chk("midreset_lo", lo, 0);
    repeat (40) @(negedge clk);

    // Back-to-back: start is held high, and MULTU is accepted on the done cycle.
    issue(3'd3, 32'd1000, 32'd7);
    while (cyc + 1 < free_edge) issue(3'd1, 32'h0001_0001, 32'hFFFF_0003);
    issue(3'd1, 32'h0001_0001, 32'hFFFF_0003);
    wait_idle();

    issue(3'd1, 32'd6, 32'd7); wait_idle();

    // Randomized traffic with random gaps, which includes starts while busy.
    for (int i = 0; i < 60; i++) begin
      a = rand_operand();
      b = rand_operand();
      issue(3'($urandom_range(0, 7)), a, b);
      repeat ($urandom_range(0, 40)) @(negedge clk);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(sb.size()), 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mips_muldiv_unit.md
Name: mips_muldiv_unit

Overview:
- Parametrised multi-cycle multiply/divide unit that owns the HI/LO register pair.
- Successor to the single-cycle HILO logic in the ALU. Adds a start/busy/done handshake, signed and unsigned variants, defined divide-by-zero and overflow results, and explicit HI/LO writes.
- Sits beside the ALU in the execute stage. The control unit stalls the pipeline while busy=1 and reads hi/lo for MFHI/MFLO.

Parameters:
- WIDTH, 32: operand, HI and LO width; must be even and at least 4.
- CNT_W, $clog2(WIDTH): iteration counter width (derived; do not override).

Ports:
- clk, input, 1: clock; all state updates on posedge.
- reset, input, 1: synchronous, active-high reset.
- start, input, 1: request strobe, sampled on posedge.
- op, input, 3: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO, others reserved.
- src_a, input, WIDTH: multiplicand / dividend / MTHI-MTLO data.
- src_b, input, WIDTH: multiplier / divisor.
- busy, output, 1: operation in progress; new starts are dropped.
- done, output, 1: one-cycle pulse when a MULT/DIV result is written to hi/lo.
- dropped, output, 1: one-cycle pulse when start is ignored (busy or reserved op).
- hi, output, WIDTH: HI register.
- lo, output, WIDTH: LO register.

Behaviour:
- Reset: on a posedge with reset=1, state=IDLE and busy, done, dropped, hi, lo, counter all clear to 0. Reset overrides start and aborts any operation in flight with no hi/lo update.
- States: IDLE, MUL, DIV, FIX.
- IDLE, start=1, op=MULT/MULTU:
  - Latch operands: absolute values for signed ops, plus result-sign flags.
  - Go to MUL with counter=0.
- IDLE, start=1, op=DIV/DIVU: same latching, go to DIV.
- IDLE, start=1, op=MTHI/MTLO:
  - hi (resp. lo) <= src_a on that edge.
  - Stay in IDLE; no busy, no done.
- MUL: shift-add, one multiplier bit per edge, 2*WIDTH-bit unsigned product accumulator.
- DIV: restoring division, one quotient bit per edge, WIDTH-bit partial remainder.
- Leaving MUL/DIV: after WIDTH iteration edges (counter reaches WIDTH-1), go to FIX.
- FIX (one edge):
  - Apply sign fixup and write {hi, lo}.
  - done=1 for the following cycle; return to IDLE.
- busy=1 exactly in MUL, DIV and FIX.
- Latency: accept edge E0; done is high in the cycle after edge E0+WIDTH+1, i.e. busy high for WIDTH+1 cycles. A new start is accepted on the edge where done is high.
- Multiply result: {hi, lo} = full 2*WIDTH-bit product.
  - MULT: two's-complement signed, product negated if the operand signs differ.
  - MULTU: unsigned.
- Divide result: lo = quotient, hi = remainder.
  - Signed: quotient truncates toward zero; remainder takes the dividend's sign.
- Divide by zero (src_b=0, latched at accept): normal latency.
  - lo = all ones.
  - hi = src_a as latched (original signed value for DIV).
- Signed overflow (DIV, src_a = most negative, src_b = -1): lo = most negative, hi = 0.
- hi/lo are unchanged from accept until the FIX edge, so MFHI/MFLO read old values while busy.
- Reserved op with start=1 in IDLE: no state change; dropped=1 next cycle.
- start=1 while busy: ignored, operation continues unaffected; dropped=1 next cycle.
- Operands are sampled only at accept; src_a/src_b may change freely while busy.

Optional Feature:
- Macro MULDIV_FAST_MUL_EN.
- Defined:
  - MULT/MULTU compute the product with a single combinational multiplier on the accept edge, then go directly to FIX.
  - Multiply latency is 2 cycles (done high in the cycle after edge E0+1; busy high for 1 cycle).
  - Division is unchanged.
- Undefined:
  - Iterative shift-add multiply as above, with no hardware multiplier inferred.
- Results are bit-identical in both builds.

Test Plan:
- All tests use WIDTH=32.
- Reset: after reset then MULTU a=0xFFFFFFFF, b=0xFFFFFFFF → done after 33 cycles; hi=0xFFFFFFFE, lo=0x00000001; busy low again the same cycle.
- Signed multiply: MULT a=0xFFFFFFFD (-3), b=7 → hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=-7, b=2 → lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). DIVU a=7, b=2 → lo=3, hi=1.
- Divide corners: DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x1234. DIV a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Handshake: MULT issued, then start with MTHI 0xAAAA at cycle 5 → dropped pulses once; hi ends with the product, not 0xAAAA. MTLO 0x55 in IDLE → lo=0x55 next cycle, busy stays 0.
- Mid-operation reset: DIVU started, reset asserted at cycle 10 → next cycle busy=0, hi=lo=0, done never pulses.
- Back-to-back and fast multiply: start held high with DIVU, then MULTU → second op accepted on the done cycle and completes correctly. With MULTU_FAST_MUL_EN... i.e. with MULDIV_FAST_MUL_EN defined, MULTU 6×7 → done 2 cycles after accept, lo=42, hi=0.
